// File: rtl/core_general.sv
`default_nettype none
// ============================================================================
//  Package     : core_general
//  Description : Core-wide constants shared by the fetch path: datapath
//                width, reset vector, canonical NOP encoding and the
//                instruction alignment (log2 of instruction size in bytes).
//  Revision    : 1.0 - initial release
// ============================================================================
package core_general;

    localparam int          XLEN         = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;  // addi x0, x0, 0
    localparam int          INST_ALIGN   = 2;

endpackage : core_general
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Synchronous FIFO with push/pop/flush and count/empty/full
//                status. The head entry is presented combinationally on dout.
//                Flush has priority over push and pop in the same cycle.
//  Ports       : clk, rst_n (async, active-low)
//                push/din  - write one entry (ignored when full unless popping)
//                pop       - remove the head entry (ignored when empty)
//                flush     - discard all entries
//                dout      - head entry
//                count     - number of stored entries (0..DEPTH)
//                empty/full- status flags
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4     // power of two, >= 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign empty = (r_count == '0);
    assign full  = (r_count == (c_AW+1)'(DEPTH));
    assign w_rd  = pop & ~empty;
    assign w_wr  = push & (~full | w_rd);
    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + c_AW'(1);
            r_count <= r_count + (c_AW+1)'(w_wr) - (c_AW+1)'(w_rd);
        end
    end

    // Storage carries no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= din;
    end

endmodule : fetch_queue
`default_nettype wire

// File: rtl/fetch_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_prefetch
//  Description : Fetch stage with sequential prefetch. Owns the architectural
//                PC, issues requests to a variable-latency instruction memory
//                (req/gnt/rvalid), buffers responses in a QDEPTH-entry queue
//                and hands one instruction to Decode per phase_fetch.
//                A jump at WriteBack flushes the queue and discards all
//                responses still in flight.
//  Ports       : clk, rst_n (async, active-low)
//                phase_fetch / phase_writeback  - phase strobes from the FSM
//                jump_state_mf / regdata_for_pc - redirect request and target
//                imem_req/addr/gnt/rvalid/rdata - instruction memory port
//                curr_pc_fd/next_pc_fd/inst     - issued instruction to Decode
//                stall_fetch                    - fetch cannot complete
//                fetch_misalign/misalign_addr   - only with the macro below
//  Config      : FETCH_MISALIGN_TRAP_EN - trap on misaligned jump targets
//                (sticky flag, prefetch halts until reset). Without it the
//                target's low bits are cleared.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch #(
    parameter int              XLEN         = core_general::XLEN,
    parameter int              AWIDTH       = 14,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(core_general::RESET_VECTOR),
    parameter int              QDEPTH       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              phase_fetch,
    input  logic              phase_writeback,
    input  logic              jump_state_mf,
    input  logic [XLEN-1:0]   regdata_for_pc,
    output logic              imem_req,
    output logic [AWIDTH-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [XLEN-1:0]   imem_rdata,
    output logic [XLEN-1:0]   curr_pc_fd,
    output logic [XLEN-1:0]   next_pc_fd,
    output logic [XLEN-1:0]   inst,
    output logic              stall_fetch
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic              fetch_misalign,
    output logic [XLEN-1:0]   misalign_addr
`endif
);

    import core_general::*;

    localparam int              c_CW         = $clog2(QDEPTH) + 1;
    localparam logic [XLEN-1:0] c_STEP       = XLEN'(1 << INST_ALIGN);
    localparam logic [XLEN-1:0] c_ALIGN_MASK = ~XLEN'((1 << INST_ALIGN) - 1);

    logic [XLEN-1:0]   r_pc;            // architectural PC
    logic [XLEN-1:0]   r_pf_pc;         // next address to request
    logic [c_CW-1:0]   r_outstanding;   // granted, response not yet seen
    logic [c_CW-1:0]   r_discard;       // responses still to be dropped

    logic              w_flush;
    logic              w_halt;
    logic              w_credit;
    logic              w_gnt;
    logic              w_rsp_keep;
    logic              w_pop;
    logic [XLEN-1:0]   w_target;

    logic [2*XLEN-1:0] w_q_head;
    logic [c_CW-1:0]   w_q_count;
    logic              w_q_empty;
    logic              w_q_full;
    logic [XLEN-1:0]   w_tag_head;
    logic [c_CW-1:0]   w_tag_count;
    logic              w_tag_empty;
    logic              w_tag_full;
    logic              w_unused;

    assign w_flush = phase_writeback & jump_state_mf;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic            r_misalign;
    logic [XLEN-1:0] r_misalign_addr;
    logic            w_misalign_jump;

    assign w_misalign_jump = w_flush & (regdata_for_pc[INST_ALIGN-1:0] != '0);
    assign w_target        = regdata_for_pc;
    assign w_halt          = r_misalign;
    assign fetch_misalign  = r_misalign;
    assign misalign_addr   = r_misalign_addr;

    // Sticky until reset; the first offending target is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign      <= 1'b0;
            r_misalign_addr <= '0;
        end else if (w_misalign_jump && !r_misalign) begin
            r_misalign      <= 1'b1;
            r_misalign_addr <= regdata_for_pc;
        end
    end
`else
    assign w_target = regdata_for_pc & c_ALIGN_MASK;
    assign w_halt   = 1'b0;
`endif

    // A slot is reserved for every outstanding request (including ones that
    // will be discarded), so the data queue can never overflow.
    assign w_credit   = ({1'b0, w_q_count} + {1'b0, r_outstanding})
                        < (c_CW+1)'(QDEPTH);
    // rst_n gating keeps req low while reset is held and lets the first
    // request go out in the very first cycle after release.
    assign imem_req   = rst_n & ~w_flush & ~w_halt & w_credit;
    assign imem_addr  = r_pf_pc[AWIDTH-1:0];
    assign w_gnt      = imem_req & imem_gnt;
    assign w_rsp_keep = imem_rvalid & (r_discard == '0);
    assign w_pop      = phase_fetch & ~w_q_empty & ~w_halt;
    assign stall_fetch = phase_fetch & (w_q_empty | w_halt);

    // Data queue: {pc_tag, instruction}. A response arriving with a flush
    // belongs to the old stream and is dropped by the flush priority.
    fetch_queue #(
        .WIDTH (2*XLEN),
        .DEPTH (QDEPTH)
    ) u_data_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_rsp_keep),
        .din   ({w_tag_head, imem_rdata}),
        .pop   (w_pop),
        .flush (w_flush),
        .dout  (w_q_head),
        .count (w_q_count),
        .empty (w_q_empty),
        .full  (w_q_full)
    );

    // Tag FIFO: address of each kept outstanding request, oldest at head.
    // Tags of requests that will be discarded are cleared by the flush, so
    // dropped responses never pop it.
    fetch_queue #(
        .WIDTH (XLEN),
        .DEPTH (QDEPTH)
    ) u_tag_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_gnt),
        .din   (r_pf_pc),
        .pop   (w_rsp_keep),
        .flush (w_flush),
        .dout  (w_tag_head),
        .count (w_tag_count),
        .empty (w_tag_empty),
        .full  (w_tag_full)
    );

    // Status bits the control logic has no use for.
    assign w_unused = ^{w_q_full, w_tag_count, w_tag_empty, w_tag_full};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_VECTOR;
            r_pf_pc       <= RESET_VECTOR;
            r_outstanding <= '0;
            r_discard     <= '0;
            curr_pc_fd    <= '0;
            next_pc_fd    <= '0;
            inst          <= XLEN'(NOP_INST);
        end else begin
            if (phase_writeback)
                r_pc <= jump_state_mf ? w_target : r_pc + c_STEP;

            if (w_flush)
                r_pf_pc <= w_target;
            else if (w_gnt)
                r_pf_pc <= r_pf_pc + c_STEP;

            r_outstanding <= r_outstanding + c_CW'(w_gnt) - c_CW'(imem_rvalid);

            // Everything in flight at the jump is stale; a response landing
            // in the jump cycle itself is already being dropped.
            if (w_flush)
                r_discard <= r_outstanding - c_CW'(imem_rvalid);
            else if (imem_rvalid && (r_discard != '0))
                r_discard <= r_discard - c_CW'(1);

            if (w_pop) begin
                curr_pc_fd <= w_q_head[2*XLEN-1:XLEN];
                next_pc_fd <= w_q_head[2*XLEN-1:XLEN] + c_STEP;
                inst       <= w_q_head[XLEN-1:0];
            end
        end
    end

    // The instruction handed to Decode must be the one at the architectural PC.
    a_head_is_pc : assert property (@(posedge clk) disable iff (!rst_n)
        w_pop |-> (w_q_head[2*XLEN-1:XLEN] == r_pc));

endmodule : fetch_prefetch
`default_nettype wire

// File: tb/tb_fetch_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_prefetch
//  Description : Directed self-checking bench for fetch_prefetch. A small
//                memory model grants in the request cycle and answers in
//                order after a programmable latency; a phase sequencer issues
//                fetch / writeback phases like the core state machine.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch;

    localparam int c_QD = 4;

    logic        clk;
    logic        rst_n;
    logic        phase_fetch;
    logic        phase_writeback;
    logic        jump_state_mf;
    logic [31:0] regdata_for_pc;
    logic        imem_req;
    logic [13:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] curr_pc_fd;
    logic [31:0] next_pc_fd;
    logic [31:0] inst;
    logic        stall_fetch;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misalign;
    logic [31:0] misalign_addr;
`endif

    fetch_prefetch u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .phase_fetch     (phase_fetch),
        .phase_writeback (phase_writeback),
        .jump_state_mf   (jump_state_mf),
        .regdata_for_pc  (regdata_for_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .curr_pc_fd      (curr_pc_fd),
        .next_pc_fd      (next_pc_fd),
        .inst            (inst),
`ifdef FETCH_MISALIGN_TRAP_EN
        .fetch_misalign  (fetch_misalign),
        .misalign_addr   (misalign_addr),
`endif
        .stall_fetch     (stall_fetch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] addr;
        int          due;
    } pend_t;

    pend_t pend[$];
    int    cyc;
    int    lat;
    logic  gnt_en;
    int    m_q;
    int    m_disc;
    int    stall_err;
    int    credit_err;
    int    flush_req_err;
    int    req_cnt;
    int    n_tests;
    int    n_fail;

    int    pc_tbl [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};

    function automatic logic [31:0] mem_word(input logic [13:0] a);
        return 32'hC0DE_0000 | {18'd0, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle, entered and left just after the falling edge.
    task automatic tick(output logic st);
        int   psz;
        logic rv;
        logic fl;
        logic pop;
        logic push;
        psz = pend.size();
        rv  = (psz > 0) && (pend[0].due <= cyc);
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_word(pend[0].addr) : 32'hDEAD_BEEF;
        imem_gnt    = gnt_en;
        #1;
        st = stall_fetch;
        fl = phase_writeback && jump_state_mf;
        if (phase_fetch && (stall_fetch !== (m_q == 0))) stall_err++;
        if (imem_req && ((m_q + psz) >= c_QD)) credit_err++;
        if (fl && imem_req) flush_req_err++;
        if (imem_req) req_cnt++;
        pop  = phase_fetch && (m_q > 0);
        push = rv && (m_disc == 0) && !fl;
        if (fl) begin
            m_q    = 0;
            m_disc = psz - int'(rv);
        end else begin
            m_q = m_q + int'(push) - int'(pop);
            if (rv && (m_disc > 0)) m_disc--;
        end
        if (imem_req && imem_gnt) pend.push_back('{imem_addr, cyc + lat});
        if (rv) void'(pend.pop_front());
        @(posedge clk);
        cyc++;
        @(negedge clk);
        imem_rvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        logic st;
        for (int i = 0; i < n; i++) tick(st);
    endtask

    task automatic do_reset(input bit chk);
        @(negedge clk);
        rst_n = 1'b0;
        phase_fetch = 1'b0; phase_writeback = 1'b0; jump_state_mf = 1'b0;
        regdata_for_pc = '0; imem_rvalid = 1'b0; gnt_en = 1'b1;
        pend.delete();
        m_q = 0; m_disc = 0;
        #1;
        if (chk) begin
            check("rst_curr_pc", curr_pc_fd, 32'h0);
            check("rst_next_pc", next_pc_fd, 32'h0);
            check("rst_inst",    inst,       32'h0000_0013);
            check("rst_req",     imem_req,   1'b0);
            check("rst_stall",   stall_fetch, 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
            check("rst_misalign", fetch_misalign, 1'b0);
`endif
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        #1;
    endtask

    task automatic do_fetch(input string tag, input logic [31:0] exp_pc,
                            input int exp_stall);
        logic st;
        int   stalls;
        bit   done;
        stalls = 0;
        done   = 1'b0;
        phase_fetch = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            tick(st);
            if (st) stalls++;
            else    done = 1'b1;
        end
        phase_fetch = 1'b0;
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_pc"},   curr_pc_fd, exp_pc);
        check({tag, "_next"}, next_pc_fd, exp_pc + 32'd4);
        check({tag, "_inst"}, inst, 32'hC0DE_0000 | exp_pc);
        if (exp_stall >= 0) check({tag, "_stalls"}, stalls, exp_stall);
    endtask

    task automatic do_wb(input logic jmp, input logic [31:0] tgt);
        logic st;
        phase_writeback = 1'b1;
        jump_state_mf   = jmp;
        regdata_for_pc  = tgt;
        tick(st);
        phase_writeback = 1'b0;
        jump_state_mf   = 1'b0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        stall_err = 0; credit_err = 0; flush_req_err = 0; req_cnt = 0;
        rst_n = 1'b0; imem_gnt = 1'b1; imem_rdata = '0;
        lat = 1;

        // 1-cycle memory, phase_fetch every 4 cycles: never stalls.
        do_reset(1'b1);
        check("first_req",  imem_req,  1'b1);
        check("first_addr", imem_addr, 14'h0);
        idle(2);
        for (int i = 0; i < 6; i++) begin
            do_fetch($sformatf("seq%0d", i), pc_tbl[i], 0);
            idle(2);
            do_wb(1'b0, 32'h0);
        end

        // Reset mid-stream, restart from the reset vector.
        do_reset(1'b1);
        do_fetch("restart", 32'h0, 2);

        // 5-cycle memory: first fetch waits for the first response.
        lat = 5;
        do_reset(1'b0);
        do_fetch("lat5_0", 32'h0, 6);
        for (int i = 1; i < 5; i++) begin
            do_wb(1'b0, 32'h0);
            do_fetch($sformatf("lat5_%0d", i), pc_tbl[i], -1);
        end

        // Jump with three requests in flight (gnt withheld once).
        do_reset(1'b0);
        idle(3);
        gnt_en = 1'b0;
        idle(1);
        gnt_en = 1'b1;
        do_wb(1'b1, 32'h100);
        do_fetch("jmp100", 32'h100, 6);
        do_wb(1'b0, 32'h0);
        do_fetch("jmp104", 32'h104, -1);

        // Jump in the same cycle as a response.
        lat = 1;
        do_reset(1'b0);
        idle(2);
        do_wb(1'b1, 32'h200);
        do_fetch("jmp200", 32'h200, 2);
        do_wb(1'b0, 32'h0);
        do_fetch("jmp204", 32'h204, -1);

        // Misaligned jump target.
        do_reset(1'b0);
        idle(2);
        do_wb(1'b1, 32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("misalign_flag", fetch_misalign, 1'b1);
        check("misalign_addr", misalign_addr,  32'h102);
        begin
            logic st;
            int   stalls;
            stalls = 0;
            req_cnt = 0;
            phase_fetch = 1'b1;
            for (int i = 0; i < 8; i++) begin
                tick(st);
                if (st) stalls++;
            end
            phase_fetch = 1'b0;
            check("misalign_req",   req_cnt, 0);
            check("misalign_stall", stalls,  8);
        end
`else
        do_fetch("align100", 32'h100, 2);
`endif

        check("stall_exact", stall_err,     0);
        check("credit",      credit_err,    0);
        check("flush_req",   flush_req_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fetch_prefetch
`default_nettype wire

// File: doc/fetch_prefetch.md
# fetch_prefetch

Parametrised successor to the single-cycle fetch stage: owns the architectural program counter, prefetches sequential instructions from an instruction memory with variable latency (req/gnt/rvalid handshake) into a QDEPTH-entry queue, and hands one instruction per `phase_fetch` to Decode. It sits between the state machine, the MemoryAccess redirect path and instruction memory. Jumps flush the queue and discard in-flight responses. `stall_fetch` is raised when Decode needs an instruction that has not yet arrived.

## Interface
- `XLEN`, 32, data/PC width
- `AWIDTH`, 14, instruction memory byte-address width (`AWIDTH` ≤ `XLEN`)
- `RESET_VECTOR`, 32'h0000_0000, PC after reset
- `QDEPTH`, 4, prefetch queue entries; power of two, ≥ 2
- `clk`  in  1  global clock
- `rst_n`  in  1  reset, asynchronous, active-low; clock `clk`
- `phase_fetch`  in  1  Fetch phase; pop one instruction
- `phase_writeback`  in  1  WriteBack phase; architectural PC update
- `jump_state_mf`  in  1  redirect to `regdata_for_pc` at WriteBack
- `regdata_for_pc`  in  XLEN  jump target
- `imem_req`  out  1  request valid
- `imem_addr`  out  AWIDTH  request byte address = prefetch PC[AWIDTH-1:0]
- `imem_gnt`  in  1  request accepted this cycle
- `imem_rvalid`  in  1  response valid; responses in order, ≥ 1 cycle after gnt
- `imem_rdata`  in  XLEN  response data
- `curr_pc_fd`  out  XLEN  PC of issued instruction
- `next_pc_fd`  out  XLEN  `curr_pc_fd + 4`
- `inst`  out  XLEN  issued instruction, registered
- `stall_fetch`  out  1  Fetch phase cannot complete
- `fetch_misalign`  out  1  (macro only) misaligned jump target seen
- `misalign_addr`  out  XLEN  (macro only) offending target

## Operation
- `pc`: architectural. At `phase_writeback`: `pc <= jump_state_mf ? regdata_for_pc : pc+4`, modulo 2^XLEN.
- `pf_pc`: next address to request. Advances by 4 on each `imem_req & imem_gnt`.
- Credits: `imem_req = !flush_pending & (q_count + outstanding < QDEPTH)`. The queue never overflows.
- `outstanding` counts granted requests without a response; width clog2(QDEPTH)+1.
- Response with `discard == 0`: push `{pc_tag, imem_rdata}` into the queue. `pc_tag` is the address of the oldest outstanding request, held in a QDEPTH-deep tag FIFO.
- Response with `discard != 0`: drop it and decrement `discard`.
- Jump at WriteBack:
  - Clear the queue.
  - `discard <= outstanding` (minus 1 if `rvalid` is present this cycle).
  - `pf_pc <= target`.
  - `imem_req` is forced 0 in that cycle.
- `phase_fetch` with queue non-empty: pop the head; `{curr_pc_fd, next_pc_fd, inst} <= {tag, tag+4, data}`; `stall_fetch = 0`.
- `phase_fetch` with queue empty: `stall_fetch = 1` (combinational); outputs hold. The state machine holds `phase_fetch` until the stall clears.
- The queue head tag always equals `pc`; the checker asserts this.
- Push and pop in the same cycle are legal; `q_count` is unchanged.

## Timing
- Reset values:
  - `pc`, `pf_pc` = `RESET_VECTOR`
  - `curr_pc_fd` = 0, `next_pc_fd` = 0
  - `inst` = 32'h0000_0013 (NOP)
  - `imem_req` = 0, `stall_fetch` = 0
  - counters 0; `fetch_misalign` 0
- First `imem_req` is in the first clock after `rst_n` release.
- With a 1-cycle memory (gnt same cycle, rvalid next cycle), the queue entry is visible 2 cycles after the request. `phase_fetch` no earlier than cycle 2 after reset sees no stall.
- Throughput: one request per cycle while credits remain.
- Pop is visible on outputs the cycle after `phase_fetch`.
- Flush coincident with push: the push is dropped.
- Flush coincident with gnt: impossible, because req is forced low.
- Reset mid-operation clears everything. In-flight responses after reset are the memory's responsibility; the memory is also reset.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A jump with `regdata_for_pc[1:0] != 0` sets sticky `fetch_misalign` and captures `misalign_addr`.
  - Prefetch halts (`imem_req = 0`) until reset.
  - Decode sees `stall_fetch = 1`.
- Undefined:
  - Target bits [1:0] are forced to 0.
  - `fetch_misalign` and `misalign_addr` ports are absent.

## Structure
- Shared package `core_general`: `XLEN`, `RESET_VECTOR`, `NOP_INST` (32'h0000_0013), `INST_ALIGN` (2).
- Sub-module `fetch_queue`: synchronous FIFO, parameters `WIDTH`, `DEPTH`, with push/pop/flush, count/empty/full. It is instantiated twice: the data queue (width 2·XLEN) and the outstanding-tag FIFO (width XLEN).

## Test plan
- Reset, 1-cycle memory, `phase_fetch` every 4 cycles → `curr_pc_fd` 0x0, 0x4, 0x8…; `inst` matches the memory image; `stall_fetch` never 1.
- Memory with 5-cycle latency → `stall_fetch = 1` exactly while the queue is empty; no request issued while `q_count + outstanding = QDEPTH`.
- Jump to 0x100 with 3 requests outstanding → 3 responses dropped; next `curr_pc_fd = 0x100`; `inst = mem[0x100]`.
- `imem_rvalid` in the same cycle as the jump flush → data is not enqueued; `discard` ends at 0.
- `rst_n` pulsed low mid-stream → all outputs return to reset values; fetch restarts at `RESET_VECTOR`.
- `FETCH_MISALIGN_TRAP_EN`, jump to 0x102 → `fetch_misalign = 1`, `misalign_addr = 0x102`, `imem_req` stays 0.
